// File: rtl/fifo_stream_reader.sv
// Reads pkt_len words from a first-word-fall-through FIFO into a stream through a 2-entry skid buffer.
// One-cycle pop-to-beat latency. r_ready depends only on registered state and fifo_empty, so m_tready stalls are absorbed by the buffer.
module fifo_stream_reader #(
    parameter int WIDTH    = 32,
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    data_in,
    output logic                r_ready,
    input  logic                start,
    input  logic [LEN_BITS-1:0] pkt_len,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [WIDTH-1:0]    m_tdata,
    output logic                m_tlast,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] remaining_q, remaining_d;
    logic [1:0]          count_q, count_d;
    logic [WIDTH-1:0]    data0_q, data0_d, data1_q, data1_d;
    logic                last0_q, last0_d, last1_q, last1_d;
    logic                done_q, done_d;
    logic                pop, retire;
    logic [1:0]          wr_slot;

    assign pop      = (state_q == RUN) && !fifo_empty && (remaining_q != '0) && (count_q != 2'd2);
    assign retire   = (count_q != 2'd0) && m_tready;
    assign wr_slot  = count_q - {1'b0, retire};

    assign r_ready  = pop;
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = data0_q;
    assign m_tlast  = last0_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q + {1'b0, pop} - {1'b0, retire};
        data0_d     = data0_q;
        data1_d     = data1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        done_d      = 1'b0;

        // Slot 0 is always the oldest beat; a retire shifts slot 1 down before the new word lands.
        if (retire) begin
            data0_d = data1_q;
            last0_d = last1_q;
        end
        if (pop) begin
            if (wr_slot == 2'd0) begin
                data0_d = data_in;
                last0_d = (remaining_q == LEN_BITS'(1));
            end else begin
                data1_d = data_in;
                last1_d = (remaining_q == LEN_BITS'(1));
            end
            remaining_d = remaining_q - LEN_BITS'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (pkt_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = pkt_len;
                    end
                end
            end
            RUN: begin
                if (pop && (remaining_q == LEN_BITS'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (retire && last0_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: queue-based FIFO and output model compared every cycle, plus literal checks per scenario.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] data_in;
    logic        r_ready;
    logic        start;
    logic [15:0] pkt_len;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        busy;
    logic        done;

    fifo_stream_reader #(.WIDTH(32), .LEN_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .r_ready    (r_ready),
        .start      (start),
        .pkt_len    (pkt_len),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Upstream FIFO contents and observation logs
    logic [31:0] fifo[$];
    bit          hold_empty;
    int          pops;
    int          cyc;
    int          done_cyc;
    logic [31:0] log_d[$];
    bit          log_l[$];
    int          log_c[$];

    // Model: packet active flag, words still to fetch, beats awaiting acceptance
    bit          m_busy;
    int          m_rem;
    logic [32:0] m_q[$];
    bit          m_done;
    bit          mv;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          exp_rr, mpop, mret, pop_obs, was_idle;
        logic [32:0] b;
        fifo_empty = (fifo.size() == 0) || hold_empty;
        data_in    = (fifo.size() != 0) ? fifo[0] : 32'd0;
        #4;
        exp_rr = m_busy && (m_rem != 0) && !fifo_empty && (m_q.size() < 2);
        mpop   = mv && exp_rr;
        mret   = mv && (m_q.size() != 0) && m_tready;
        if (mv) begin
            chk("r_ready", r_ready, exp_rr);
            chk("m_tvalid", m_tvalid, m_q.size() != 0);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_q.size() != 0) begin
                chk("m_tdata", m_tdata, m_q[0][31:0]);
                chk("m_tlast", m_tlast, m_q[0][32]);
            end
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        pop_obs = (r_ready === 1'b1) && !fifo_empty;
        if (reset && m_tvalid === 1'b1 && m_tready) begin
            log_d.push_back(m_tdata);
            log_l.push_back(m_tlast);
            log_c.push_back(cyc);
        end
        @(posedge clk);
        if (!reset) begin
            m_busy = 0;
            m_rem  = 0;
            m_q.delete();
            m_done = 0;
            mv     = 1;
        end else if (mv) begin
            was_idle = !m_busy;
            m_done   = 0;
            if (mret) begin
                b = m_q.pop_front();
                if (b[32]) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (mpop) begin
                m_q.push_back({m_rem == 1, fifo[0]});
                m_rem--;
            end
            if (was_idle && start) begin
                if (pkt_len == 16'd0) m_done = 1;
                else begin
                    m_busy = 1;
                    m_rem  = int'(pkt_len);
                end
            end
        end
        if (pop_obs) begin
            void'(fifo.pop_front());
            pops++;
        end
        cyc++;
        #1;
    endtask

    task automatic run_until_done(input string n, input int bound);
        int k = 0;
        while (done_cyc < 0 && k < bound) begin
            tick();
            k++;
        end
        chk({n, "_done_seen"}, done_cyc >= 0, 1);
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_c.delete();
        pops     = 0;
        done_cyc = -1;
    endtask

    task automatic check_log(input string n, input int cnt, input logic [31:0] base, input bit consec);
        chk({n, "_beats"}, log_d.size(), cnt);
        for (int i = 0; i < log_d.size() && i < cnt; i++) begin
            chk({n, "_data"}, log_d[i], base + i);
            chk({n, "_last"}, log_l[i], i == cnt - 1);
            if (consec && i > 0) chk({n, "_gap"}, log_c[i] - log_c[i-1], 1);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        pkt_len    = 16'd0;
        m_tready   = 1'b0;
        hold_empty = 0;
        fifo_empty = 1'b1;
        data_in    = 32'd0;
        mv         = 0;
        cyc        = 0;
        clear_logs();

        // Reset values
        tick();
        tick();
        chk("rst_r_ready", r_ready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Idle with a non-empty FIFO: nothing moves
        fifo.push_back(32'd1);
        fifo.push_back(32'd2);
        fifo.push_back(32'd3);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_pops", pops, 0);

        // Three-word packet at full throughput
        m_tready = 1'b1;
        clear_logs();
        start = 1'b1; pkt_len = 16'd3;
        tick();
        start = 1'b0;
        run_until_done("full", 20);
        check_log("full", 3, 32'd1, 1);
        chk("full_pops", pops, 3);
        chk("full_done_lag", done_cyc - (log_c.size() > 0 ? log_c[log_c.size()-1] : -100), 1);
        tick();
        chk("full_done_width", done, 0);

        // Downstream stall: two pops fill the buffer, head stays put
        fifo.push_back(32'd1);
        fifo.push_back(32'd2);
        fifo.push_back(32'd3);
        m_tready = 1'b0;
        clear_logs();
        start = 1'b1; pkt_len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_pops", pops, 2);
        chk("stall_tdata", m_tdata, 1);
        chk("stall_tvalid", m_tvalid, 1);
        m_tready = 1'b1;
        run_until_done("stall", 20);
        check_log("stall", 3, 32'd1, 0);
        chk("stall_total_pops", pops, 3);

        // Intermittently empty FIFO; two spare words must stay unread
        for (int i = 21; i <= 26; i++) fifo.push_back(32'(i));
        clear_logs();
        start = 1'b1; pkt_len = 16'd4;
        tick();
        start = 1'b0;
        begin
            int k = 0;
            while (done_cyc < 0 && k < 40) begin
                hold_empty = ~hold_empty;
                tick();
                k++;
            end
            chk("gappy_done_seen", done_cyc >= 0, 1);
        end
        hold_empty = 0;
        check_log("gappy", 4, 32'd21, 0);
        chk("gappy_pops", pops, 4);
        chk("gappy_left", fifo.size(), 2);
        for (int i = 0; i < 3; i++) tick();
        chk("gappy_no_extra", pops, 4);

        // Zero-length request
        clear_logs();
        start = 1'b1; pkt_len = 16'd0;
        tick();
        start = 1'b0;
        tick();
        chk("len0_done", done_cyc >= 0, 1);
        chk("len0_pops", pops, 0);
        chk("len0_beats", log_d.size(), 0);

        // Second start while busy is ignored
        clear_logs();
        start = 1'b1; pkt_len = 16'd2;
        tick();
        pkt_len = 16'd5;
        tick();
        start = 1'b0;
        fifo.push_back(32'd27);
        run_until_done("busy_start", 20);
        check_log("busy_start", 2, 32'd25, 1);
        chk("busy_start_pops", pops, 2);

        // Abort by reset mid-packet, then a fresh two-word packet
        fifo.delete();
        for (int i = 41; i <= 45; i++) fifo.push_back(32'(i));
        m_tready = 1'b0;
        clear_logs();
        start = 1'b1; pkt_len = 16'd5;
        tick();
        start = 1'b0;
        begin
            int k = 0;
            while (pops < 2 && k < 20) begin
                tick();
                k++;
            end
        end
        chk("abort_pops_before", pops, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_r_ready", r_ready, 0);
        chk("abort_m_tvalid", m_tvalid, 0);
        chk("abort_m_tdata", m_tdata, 0);
        chk("abort_m_tlast", m_tlast, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_no_done", done_cyc, -1);
        chk("abort_no_pop", pops, 2);
        clear_logs();
        start = 1'b1; pkt_len = 16'd2;
        tick();
        start = 1'b0;
        run_until_done("restart", 20);
        check_log("restart", 2, 32'd43, 1);
        chk("restart_pops", pops, 2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
